// File: rtl/dr_input_buffer.sv
// Ping-pong input tile buffer: a loader fills one bank while data_router reads whole
// rows (POY lanes x BUFW pixels) out of the other, full bank with a fixed 1-cycle latency.
module dr_input_buffer #(
   parameter int DW     = 32,
   parameter int POY    = 3,
   parameter int BUFW   = 48,
   parameter int STRIDE = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [DW-1:0]                    wr_data,
   input  logic [27:0]                      wr_tag,
   input  logic                             wr_last,
   input  logic [7:0]                       bank,
   input  logic [7:0]                       row,
   input  logic [27:0]                      col,
   input  logic [1:0]                       rpsel,
   output logic [POY-1:0][BUFW-1:0][DW-1:0] data,
   output logic                             rd_hit,
   output logic                             blkend,
   output logic [1:0]                       bank_full
);

   localparam int NBANK = 2;
   localparam int BUFH  = STRIDE + 1;
   localparam int XW    = (BUFW > 1) ? $clog2(BUFW) : 1;
   localparam int YW    = (POY  > 1) ? $clog2(POY)  : 1;
   localparam int RW    = (BUFH > 1) ? $clog2(BUFH) : 1;

   typedef logic [POY-1:0][BUFW-1:0][DW-1:0] row_t;
   typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL} bank_state_e;

   row_t        mem     [NBANK][BUFH];
   bank_state_e state_q [NBANK];
   logic [27:0] tag_q   [NBANK];
   logic        last_q  [NBANK];
   logic        wptr_q;
   logic [XW-1:0] wr_x;
   logic [YW-1:0] wr_y;
   logic [RW-1:0] wr_r;

   logic          rd_bank;
   logic [RW-1:0] rd_row;
   logic          bank_ok;
   logic          hit_c;
   logic          rel_c;
   logic          wr_fire;
   logic          wr_end;

   assign wr_ready = rst_n && (state_q[wptr_q] != S_FULL);

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      rd_bank = bank[0];
      rd_row  = row[RW-1:0];
      bank_ok = (bank < 8'(NBANK));
      hit_c   = 1'b0;
      rel_c   = 1'b0;
      if (bank_ok && state_q[rd_bank] == S_FULL) begin
         hit_c = (rpsel == 2'b01 || rpsel == 2'b10) && (row < 8'(BUFH))
                 && (col == tag_q[rd_bank]);
         rel_c = rpsel[1];
      end
      wr_fire = wr_valid && wr_ready;
      wr_end  = wr_last || (wr_x == XW'(BUFW-1) && wr_y == YW'(POY-1)
                            && wr_r == RW'(BUFH-1));
      for (int b = 0; b < NBANK; b++) bank_full[b] = (state_q[b] == S_FULL);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read in this
   // block sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the storage is cleared on reset on purpose: unwritten entries of a bank
         // closed early by wr_last must read back as zero.
         for (int b = 0; b < NBANK; b++) begin
            for (int r = 0; r < BUFH; r++) mem[b][r] <= '0;
            state_q[b] <= S_EMPTY;
            tag_q[b]   <= '0;
            last_q[b]  <= 1'b0;
         end
         wptr_q <= 1'b0;
         wr_x   <= '0;
         wr_y   <= '0;
         wr_r   <= '0;
         data   <= '0;
         rd_hit <= 1'b0;
         blkend <= 1'b0;
      end else begin
         rd_hit <= hit_c;
         blkend <= rel_c && last_q[rd_bank];
         if (hit_c) data <= mem[rd_bank][rd_row];

         // A released bank is never the write bank (writes need a non-FULL bank).
         if (rel_c) begin
            state_q[rd_bank] <= S_EMPTY;
            last_q[rd_bank]  <= 1'b0;
            for (int r = 0; r < BUFH; r++) mem[rd_bank][r] <= '0;
         end

         if (wr_fire) begin
            mem[wptr_q][wr_r][wr_y][wr_x] <= wr_data;
            if (state_q[wptr_q] == S_EMPTY) begin
               state_q[wptr_q] <= S_FILLING;
               tag_q[wptr_q]   <= wr_tag;
            end
            if (wr_end) begin
               state_q[wptr_q] <= S_FULL;
               last_q[wptr_q]  <= wr_last;
               wptr_q          <= ~wptr_q;
               wr_x            <= '0;
               wr_y            <= '0;
               wr_r            <= '0;
            end else if (wr_x == XW'(BUFW-1)) begin
               wr_x <= '0;
               if (wr_y == YW'(POY-1)) begin
                  wr_y <= '0;
                  wr_r <= wr_r + 1'b1;
               end else begin
                  wr_y <= wr_y + 1'b1;
               end
            end else begin
               wr_x <= wr_x + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dr_input_buffer.sv
// Scoreboard bench for dr_input_buffer: the driver runs a linear-array reference model
// and queues the expected outputs per clock; a monitor pops and compares after each edge.
module tb_dr_input_buffer;

   localparam int DW     = 32;
   localparam int POY    = 3;
   localparam int BUFW   = 48;
   localparam int STRIDE = 1;
   localparam int BUFH   = STRIDE + 1;
   localparam int ROWW   = POY * BUFW;
   localparam int NW     = BUFH * ROWW;

   typedef logic [POY-1:0][BUFW-1:0][DW-1:0] row_t;
   typedef struct {
      logic       rd_hit;
      logic       blkend;
      logic [1:0] bank_full;
      logic       wr_ready;
      row_t       data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [DW-1:0] wr_data;
   logic [27:0] wr_tag;
   logic        wr_last;
   logic [7:0]  bank;
   logic [7:0]  row;
   logic [27:0] col;
   logic [1:0]  rpsel;
   row_t        data;
   logic        rd_hit;
   logic        blkend;
   logic [1:0]  bank_full;

   dr_input_buffer #(.DW(DW), .POY(POY), .BUFW(BUFW), .STRIDE(STRIDE)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_tag(wr_tag), .wr_last(wr_last), .bank(bank), .row(row),
      .col(col), .rpsel(rpsel), .data(data), .rd_hit(rd_hit), .blkend(blkend),
      .bank_full(bank_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t expq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: each bank is a flat array filled in arrival order.
   logic [DW-1:0] mm    [2][NW];
   int            st    [2];      // 0 empty, 1 filling, 2 full
   logic [27:0]   mtag  [2];
   logic          mlast [2];
   int            mwptr;
   int            mcnt;
   row_t          mdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      exp_t e;
      int   b;
      logic hit, rel, rel_last;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NW; k++) mm[i][k] = '0;
            st[i] = 0; mtag[i] = '0; mlast[i] = 1'b0;
         end
         mwptr = 0; mcnt = 0; mdata = '0;
         e.rd_hit = 1'b0; e.blkend = 1'b0; e.bank_full = 2'b00; e.wr_ready = 1'b0;
      end else begin
         b   = (bank < 2) ? int'(bank) : 0;
         hit = (rpsel == 2'b01 || rpsel == 2'b10) && bank < 2 && row < BUFH
               && st[b] == 2 && col == mtag[b];
         if (hit)
            for (int y = 0; y < POY; y++)
               for (int x = 0; x < BUFW; x++)
                  mdata[y][x] = mm[b][int'(row) * ROWW + y * BUFW + x];
         rel      = rpsel[1] && bank < 2 && st[b] == 2;
         rel_last = rel && mlast[b];
         if (wr_valid && st[mwptr] != 2) begin
            mm[mwptr][mcnt] = wr_data;
            if (st[mwptr] == 0) begin
               st[mwptr] = 1; mtag[mwptr] = wr_tag; mlast[mwptr] = 1'b0;
            end
            mcnt++;
            if (mcnt == NW || wr_last) begin
               st[mwptr] = 2; mlast[mwptr] = wr_last; mwptr = 1 - mwptr; mcnt = 0;
            end
         end
         if (rel) begin
            st[b] = 0; mlast[b] = 1'b0;
            for (int k = 0; k < NW; k++) mm[b][k] = '0;
         end
         e.rd_hit    = hit;
         e.blkend    = rel_last;
         e.bank_full = {st[1] == 2, st[0] == 2};
         e.wr_ready  = (st[mwptr] != 2);
      end
      e.data = mdata;
      expq.push_back(e);
   endtask

   // Inputs are applied at the negative edge; the model predicts the next posedge.
   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_valid = 1'b0; wr_last = 1'b0; rpsel = 2'b00;
   endtask

   task automatic fill(input int n, input logic [27:0] tag, input bit counting,
                       input bit last_at_end);
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = counting ? DW'(i) : $urandom;
         wr_tag   = tag;
         wr_last  = last_at_end && (i == n - 1);
         tick();
      end
      idle();
   endtask

   task automatic req(input int b, input int r, input int c, input logic [1:0] ps);
      bank = 8'(b); row = 8'(r); col = 28'(c); rpsel = ps;
      tick();
      rpsel = 2'b00;
   endtask

   // Monitor: one expected entry per clock edge.
   initial begin
      exp_t e;
      int   ly, lx;
      bit   diff;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("rd_hit", 32'(rd_hit), 32'(e.rd_hit));
            check("blkend", 32'(blkend), 32'(e.blkend));
            check("bank_full", 32'(bank_full), 32'(e.bank_full));
            check("wr_ready", 32'(wr_ready), 32'(e.wr_ready));
            diff = 1'b0; ly = 0; lx = 0;
            for (int y = POY - 1; y >= 0; y--)
               for (int x = BUFW - 1; x >= 0; x--)
                  if (data[y][x] !== e.data[y][x]) begin
                     diff = 1'b1; ly = y; lx = x;
                  end
            total++;
            if (diff) begin
               bad++;
               $display("FAIL data[%0d][%0d]: got %0h expected %0h at %0t",
                        ly, lx, data[ly][lx], e.data[ly][lx], $time);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; wr_valid = 1'b1; wr_data = '0; wr_tag = '0; wr_last = 1'b0;
      bank = '0; row = '0; col = '0; rpsel = 2'b00;
      repeat (3) tick();
      rst_n = 1'b1;
      idle();
      tick();

      // Bank0 with counting data; row1 lane0 pixel0 is word 144, lane2 pixel47 word 287.
      fill(NW, 28'd5, 1'b1, 1'b0);
      tick();
      req(0, 1, 5, 2'b01);
      tick();

      // Both banks full: writes stall until bank0 is released.
      fill(NW, 28'd9, 1'b0, 1'b0);
      wr_valid = 1'b1; wr_data = 32'hdead_beef;
      tick(); tick();
      idle();
      req(0, 0, 5, 2'b11);
      tick();

      // Misses hold the previous data.
      req(1, 0, 9, 2'b01);
      req(1, 0, 10, 2'b01);
      req(1, 2, 9, 2'b01);
      req(3, 0, 9, 2'b01);
      fill(20, 28'd5, 1'b0, 1'b0);
      req(0, 0, 5, 2'b01);
      req(0, 0, 5, 2'b11);
      tick();

      // Early close of bank1 by wr_last, then read+release with blkend.
      fill(NW - 20, 28'd5, 1'b0, 1'b0);
      req(1, 0, 9, 2'b11);
      tick();
      fill(11, 28'd7, 1'b0, 1'b1);
      tick();
      req(1, 1, 7, 2'b01);
      req(1, 0, 7, 2'b10);
      tick(); tick();
      req(1, 0, 7, 2'b11);
      tick();

      // Reset mid-fill discards the partial bank.
      req(0, 0, 5, 2'b11);
      fill(100, 28'd3, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      fill(NW, 28'd3, 1'b0, 1'b0);
      tick();
      req(0, 0, 3, 2'b01);
      req(0, 1, 3, 2'b01);
      tick();

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data  = $urandom;
         wr_tag   = 28'($urandom_range(0, 3));
         wr_last  = ($urandom_range(0, 40) == 0);
         rpsel    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         bank     = ($urandom_range(0, 6) == 0) ? 8'd2 : 8'($urandom_range(0, 1));
         row      = 8'($urandom_range(0, 2));
         col      = 28'($urandom_range(0, 3));
         tick();
      end
      idle();
      tick();

      for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
      if (expq.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d entries left expected 0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
